// File: rtl/upload_packer.sv
// Device-to-host frame encoder: buffers one upload packet, then emits
// HDR0 HDR1 source len_hi len_lo payload checksum with valid/ready flow control.
module upload_packer #(
  parameter int         MAX_PAYLOAD = 256,
  parameter logic [7:0] HDR0        = 8'hAA,
  parameter logic [7:0] HDR1        = 8'h55
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       upload_req,
  input  logic [7:0] upload_data,
  input  logic [7:0] upload_source,
  input  logic       upload_valid,
  output logic       upload_ready,
  output logic [7:0] packed_data,
  output logic       packed_valid,
  input  logic       packed_ready,
  output logic       overflow,
  output logic       busy
);

  localparam int AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam int CW = $clog2(MAX_PAYLOAD) + 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_PAYLOAD);

  typedef enum logic [3:0] {
    ST_IDLE, ST_COLLECT, ST_HDR0, ST_HDR1, ST_SRC,
    ST_LENH, ST_LENL, ST_PAYLOAD, ST_CSUM
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_rd_idx;
  logic [7:0]    r_src;
  logic [7:0]    r_csum;
  logic [7:0]    r_packed_data;
  logic          r_packed_valid;
  logic          r_overflow;
  logic          r_dropped;
  logic          r_req_d;
  logic [7:0]    r_mem [MAX_PAYLOAD];

  logic          w_start;
  logic          w_room;
  logic          w_wr_en;
  logic [AW-1:0] w_wr_addr;
  logic [CW-1:0] w_count_nxt;
  logic          w_accept;
  logic [15:0]   w_len;
  logic [7:0]    w_rd_data;

  assign w_start     = (r_state == ST_IDLE) && upload_req && !r_req_d;
  assign w_room      = r_count < MAX_CNT;
  assign w_wr_en     = upload_valid && (w_start || (r_state == ST_COLLECT && w_room));
  assign w_wr_addr   = w_start ? '0 : r_count[AW-1:0];
  assign w_count_nxt = (w_start ? '0 : r_count) + CW'(w_wr_en);
  assign w_accept    = r_packed_valid && packed_ready;
  assign w_len       = 16'(r_count);
  assign w_rd_data   = r_mem[r_rd_idx[AW-1:0]];

  // NOTE: the payload store has no reset; its contents are only read below r_count,
  // so resetting it would cost a reset net on every bit for nothing.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_wr_addr] <= upload_data;
  end

  // The output register always holds the byte of the current emit state; on
  // acceptance the next byte is loaded in the same cycle, so there are no bubbles.
  // NOTE: sequential state uses non-blocking assignments only, so every read in
  // this block sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_count        <= '0;
      r_rd_idx       <= '0;
      r_src          <= '0;
      r_csum         <= '0;
      r_packed_data  <= '0;
      r_packed_valid <= 1'b0;
      r_overflow     <= 1'b0;
      r_dropped      <= 1'b0;
      r_req_d        <= 1'b0;
    end else begin
      r_req_d    <= upload_req;
      r_overflow <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_src     <= upload_source;
            r_count   <= w_count_nxt;
            r_rd_idx  <= '0;
            r_csum    <= '0;
            r_dropped <= 1'b0;
            r_state   <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          r_count <= w_count_nxt;
          if (upload_valid && !w_room && !r_dropped) begin
            r_overflow <= 1'b1;
            r_dropped  <= 1'b1;
          end
          if (!upload_req) begin
            if (w_count_nxt == '0) begin
              r_state <= ST_IDLE;
            end else begin
              r_state        <= ST_HDR0;
              r_packed_data  <= HDR0;
              r_packed_valid <= 1'b1;
            end
          end
        end
        ST_HDR0: if (w_accept) begin
          r_state       <= ST_HDR1;
          r_packed_data <= HDR1;
        end
        ST_HDR1: if (w_accept) begin
          r_state       <= ST_SRC;
          r_packed_data <= r_src;
          r_csum        <= r_csum + r_src;
        end
        ST_SRC: if (w_accept) begin
          r_state       <= ST_LENH;
          r_packed_data <= w_len[15:8];
          r_csum        <= r_csum + w_len[15:8];
        end
        ST_LENH: if (w_accept) begin
          r_state       <= ST_LENL;
          r_packed_data <= w_len[7:0];
          r_csum        <= r_csum + w_len[7:0];
        end
        ST_LENL: if (w_accept) begin
          r_state       <= ST_PAYLOAD;
          r_packed_data <= w_rd_data;
          r_csum        <= r_csum + w_rd_data;
          r_rd_idx      <= r_rd_idx + 1'b1;
        end
        ST_PAYLOAD: if (w_accept) begin
          if (r_rd_idx == r_count) begin
            r_state       <= ST_CSUM;
            r_packed_data <= r_csum;
          end else begin
            r_packed_data <= w_rd_data;
            r_csum        <= r_csum + w_rd_data;
            r_rd_idx      <= r_rd_idx + 1'b1;
          end
        end
        ST_CSUM: if (w_accept) begin
          r_state        <= ST_IDLE;
          r_packed_valid <= 1'b0;
        end
        default: begin
          r_state        <= ST_IDLE;
          r_packed_valid <= 1'b0;
        end
      endcase
    end
  end

  assign packed_data  = r_packed_data;
  assign packed_valid = r_packed_valid;
  assign overflow     = r_overflow;
  assign busy         = (r_state != ST_IDLE);
  assign upload_ready = (r_state == ST_IDLE) || (r_state == ST_COLLECT);

endmodule

// File: doc/upload_packer.md
Name: upload_packer

Overview:
- Frame encoder for the device-to-host path; the transmit counterpart of the host-to-device frame parser.
- Collects one upload packet from a handler (UART, I2C, ...) through the upload_req/upload_data/upload_source/upload_valid interface and buffers the payload.
- Emits a complete framed byte stream toward the USB upload path with valid/ready flow control.
- Frame on wire: HDR0, HDR1, source, len_hi, len_lo, payload[0..len-1], checksum.

Parameters:
MAX_PAYLOAD, 256, payload buffer depth in bytes; packet length is capped here
HDR0, 8'hAA, first header byte
HDR1, 8'h55, second header byte

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
upload_req  input  1  high for the whole duration of one packet from the handler
upload_data  input  8  payload byte
upload_source  input  8  packet source ID; sampled on the rising edge of upload_req
upload_valid  input  1  upload_data is valid this cycle
upload_ready  output  1  high in IDLE and COLLECT; handler must not start a packet while low
packed_data  output  8  framed output byte
packed_valid  output  1  packed_data is valid
packed_ready  input  1  downstream accepts the byte when packed_valid && packed_ready
overflow  output  1  one-cycle pulse on the first dropped byte of a packet
busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low. The clock port is clk and the reset port is rst_n.
- Reset values:
  - packed_data=0, packed_valid=0, overflow=0, busy=0, upload_ready=1.
  - State=IDLE; byte count=0; checksum=0.
- States: IDLE, COLLECT, HDR0, HDR1, SRC, LENH, LENL, PAYLOAD, CSUM.
- IDLE:
  - On upload_req rising (registered previous value 0, current value 1): latch upload_source, clear count, go to COLLECT.
  - An upload_valid in that same cycle is stored as byte 0.
- COLLECT:
  - Each cycle with upload_valid=1 and count<MAX_PAYLOAD: write the byte at buffer[count] and increment count.
  - If count==MAX_PAYLOAD: drop the byte. Pulse overflow on the first drop only.
  - When upload_req=0: an upload_valid in the same cycle is still processed as above.
  - Then, if the final count is 0, return to IDLE with no frame emitted. Otherwise go to HDR0.
- Count width: clog2(MAX_PAYLOAD)+1 bits. len_hi/len_lo are count zero-extended to 16 bits.
- Emit states:
  - Each state presents its byte with packed_valid=1 and advances only on packed_valid && packed_ready.
  - packed_data must stay stable while packed_valid=1 and packed_ready=0.
  - packed_valid may drop between bytes (for example a buffer read bubble). The emitted sequence must be exact, with no duplicated or skipped bytes.
- PAYLOAD: emits buffer[0..count-1] in order, then goes to CSUM.
- CSUM: emits checksum, then returns to IDLE on acceptance.
- Checksum: 8-bit modulo-256 sum of source, len_hi, len_lo and every emitted payload byte. Header bytes are excluded.
- During emit: upload_ready=0. upload_req/upload_valid are ignored and those bytes are lost. overflow is not asserted for them.
- A new upload_req rising edge is only detected in IDLE. A req that is still high when the packer returns to IDLE does not start a packet; a fresh 0→1 transition is needed.
- Reset mid-operation: immediate return to reset values. Partial frames are abandoned, and buffer contents are don't-care.
- Latency: the first HDR0 byte is valid no later than 2 cycles after the cycle in which upload_req is sampled low in COLLECT.

Test Plan:
- Basic frame: source 0x02, bytes 0x11 0x22 0x33, packed_ready=1 → stream AA 55 02 00 03 11 22 33 6B, then IDLE, busy=0.
- Backpressure: same packet with packed_ready toggling 1/0 every cycle → identical 9-byte stream; packed_data stable while stalled; no duplicates.
- Empty packet: upload_req high 5 cycles with no upload_valid → no packed_valid ever; back in IDLE; upload_ready=1.
- Overflow: source 0x05, 257 bytes of 0x01 with MAX_PAYLOAD=256 → single overflow pulse on byte 257; frame AA 55 05 01 00 followed by 256×01, checksum 0x06.
- Edge timing: last byte 0x44 valid in the same cycle upload_req falls, after 0x10 from source 0x03 → frame AA 55 03 00 02 10 44 59.
- Reset mid-emission: assert rst_n=0 during PAYLOAD → packed_valid=0 asynchronously; after release, a new packet (source 0x01, byte 0xFF) → AA 55 01 00 01 FF 01.
